// File: rtl/fp_inv_seq.sv
// fp_inv_seq: sequential modular inverter, result = a^-1 mod P.
// Binary extended Euclid, one reduction step per clock. A start/done
// handshake lets several point-arithmetic controllers share one instance.
//
// Handshake: start is sampled only while ready=1 (IDLE or DONE). The
// accepting edge captures a_in; a_in is a don't-care at every other
// time. start while busy (LOAD/RUN) is dropped, not queued. done is a
// one-cycle pulse. err is valid with done. result and err hold until
// the next accepted start.
module fp_inv_seq #(
    parameter int              WIDTH = 256,
    parameter logic [WIDTH-1:0] P    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] a_r;

    // x/2 mod P: odd x gets P added first (at WIDTH+1 bits) so the sum is even.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, P} : {(WIDTH+1){1'b0}});
        return s[WIDTH:1];
    endfunction

    // (a - b) mod P for a, b already in 0..P-1.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        end
        return s[WIDTH-1:0];
    endfunction

    // Single conditional subtract is enough since a < 2^WIDTH < 2P.
    assign a_r = (a_q >= P) ? (a_q - P) : a_q;

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update: one Euclid action per RUN cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (a_r == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    u_d     = a_r;
                    v_d     = P;
                    x1_d    = ONE;
                    x2_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (u_q == ONE) begin
                    result_d = x1_q;
                    state_d  = S_DONE;
                end else if (v_q == ONE) begin
                    result_d = x2_q;
                    state_d  = S_DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end
            S_DONE: begin
                // Back-to-back start is accepted in the done cycle.
                if (start) begin
                    a_d     = a_in;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_inv_seq.sv
// Bench for fp_inv_seq: directed table, randomized back-to-back runs
// against a Fermat-exponentiation reference, busy-start and mid-run
// reset sequences.
module tb_fp_inv_seq;

  localparam logic [255:0] P    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] INV2 = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;
  localparam int WATCHDOG = 1100;
  localparam int MAX_LAT  = 1027;
  localparam int N_RAND   = 80;

  logic         clk;
  logic         reset;
  logic         start;
  logic [255:0] a_in;
  logic         ready;
  logic         done;
  logic         err;
  logic [255:0] result;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_pass;

  logic [255:0] exp_q[$];

  typedef struct {
    logic [255:0] a;
    logic [255:0] res;
    logic         e;
    int           lat;   // exact latency to check, 0 = bound only
  } vec_t;

  vec_t vecs[7];

  fp_inv_seq #(.WIDTH(256), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] t;
    logic [511:0] pm;
    pm = {256'b0, P};
    t  = {256'b0, x} * {256'b0, y};
    t  = t % pm;
    return t[255:0];
  endfunction

  // Fermat: x^(P-2) mod P, with x reduced first; 0 maps to 0.
  function automatic logic [255:0] inv_model(input logic [255:0] x);
    logic [255:0] e;
    logic [255:0] r;
    logic [255:0] b;
    b = (x >= P) ? x - P : x;
    e = P - 256'd2;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // ---------------- driver ----------------
  // Entered at #1 after an edge with the DUT expected ready. Returns at
  // #1 after the edge that raised done (or when the watchdog expires).
  task automatic run_op(input logic [255:0] a, output logic [255:0] r,
                        output logic e, output int lat);
    chk("ready_before_start", {255'b0, ready}, 256'd1);
    start = 1'b1;
    a_in  = a;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = rand256();
    lat   = 1;
    while (!done && lat < WATCHDOG) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("watchdog_done", {255'b0, done}, 256'd1);
    r = result;
    e = err;
    if (!done) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [255:0] r;
    logic [255:0] a;
    logic [255:0] inv3;
    logic         e;
    int           lat;
    int           n_done;

    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a_in     = '0;

    vecs[0] = '{a: 256'd1,            res: 256'd1,  e: 1'b0, lat: 3};
    vecs[1] = '{a: 256'd2,            res: INV2,    e: 1'b0, lat: 0};
    vecs[2] = '{a: P - 256'd1,        res: P - 256'd1, e: 1'b0, lat: 0};
    vecs[3] = '{a: 256'd0,            res: 256'd0,  e: 1'b1, lat: 0};
    vecs[4] = '{a: P,                 res: 256'd0,  e: 1'b1, lat: 0};
    vecs[5] = '{a: P + 256'd1,        res: 256'd1,  e: 1'b0, lat: 3};
    vecs[6] = '{a: {256{1'b1}},       res: inv_model({256{1'b1}}), e: 1'b0, lat: 0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_ready",  {255'b0, ready},  256'd1);
    chk("rst_done",   {255'b0, done},   256'd0);
    chk("rst_err",    {255'b0, err},    256'd0);
    chk("rst_result", result,           256'd0);

    // directed table (back-to-back through the DONE cycle)
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, r, e, lat);
      chk($sformatf("tbl%0d_result", i), r, vecs[i].res);
      chk($sformatf("tbl%0d_err", i), {255'b0, e}, {255'b0, vecs[i].e});
      if (vecs[i].lat != 0)
        chk($sformatf("tbl%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
      else
        chk($sformatf("tbl%0d_lat_bound", i), {255'b0, (lat <= MAX_LAT)}, 256'd1);
    end

    // randomized back-to-back operands with scoreboard
    for (int i = 0; i < N_RAND; i++) begin
      if (i % 4 == 0) begin
        a = 256'($urandom_range(1, 1000));
      end else begin
        do a = rand256(); while (a == '0 || a >= P);
      end
      exp_q.push_back(inv_model(a));
      run_op(a, r, e, lat);
      chk($sformatf("rnd%0d_result", i), r, exp_q.pop_front());
      chk($sformatf("rnd%0d_product", i), mulmod(a, r), 256'd1);
      chk($sformatf("rnd%0d_err", i), {255'b0, e}, 256'd0);
      chk($sformatf("rnd%0d_lat_bound", i), {255'b0, (lat <= MAX_LAT)}, 256'd1);
    end

    // done falls after one cycle, result holds, back to IDLE
    @(posedge clk); #1;
    chk("done_pulse_drop", {255'b0, done}, 256'd0);
    chk("result_hold", result, r);
    chk("idle_ready", {255'b0, ready}, 256'd1);

    // start while busy is ignored
    inv3  = inv_model(256'd3);
    start = 1'b1;
    a_in  = 256'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_not_ready", {255'b0, ready}, 256'd0);
    start = 1'b1;
    a_in  = 256'd5;
    @(posedge clk); #1;
    start  = 1'b0;
    a_in   = '0;
    n_done = 0;
    r      = '0;
    for (int c = 0; c < 1200; c++) begin
      if (done) begin
        n_done++;
        r = result;
      end
      @(posedge clk); #1;
    end
    chk("busy_done_count", 256'(n_done), 256'd1);
    chk("busy_result", r, inv3);
    chk("busy_result_hold", result, inv3);

    // reset in the middle of RUN
    start = 1'b1;
    a_in  = 256'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun_busy", {255'b0, ready}, 256'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready",  {255'b0, ready},     256'd1);
    chk("midrst_done",   {255'b0, done},      256'd0);
    chk("midrst_result", result,              256'd0);
    chk("midrst_err",    {255'b0, err},       256'd0);
    chk("midrst_state",  {254'b0, dbg_state}, 256'd0);
    run_op(256'd2, r, e, lat);
    chk("after_rst_result", r, INV2);
    chk("after_rst_err", {255'b0, e}, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
